// File: rtl/nn_pkg.sv
// Shared types and constants for the u-law neuron MAC: FSM states, fixed-point
// widths and the output saturation helper.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      FIN  = 2'd2,
      OUT  = 2'd3
   } state_e;

   localparam int FIX14_W   = 14;
   localparam int ACC_W_DEF = 32;
   localparam int OUT_W_DEF = 16;

   // Bounds of the signed OUT_W result, expressed at ACC_W+1 bits.
   localparam logic signed [ACC_W_DEF:0] SAT_MAX =
      $signed({{(ACC_W_DEF - OUT_W_DEF + 2){1'b0}}, {(OUT_W_DEF - 1){1'b1}}});
   localparam logic signed [ACC_W_DEF:0] SAT_MIN =
      $signed({{(ACC_W_DEF - OUT_W_DEF + 2){1'b1}}, {(OUT_W_DEF - 1){1'b0}}});

   function automatic logic signed [OUT_W_DEF-1:0] sat_to_out(input logic signed [ACC_W_DEF:0] s);
      if (s > SAT_MAX) begin
         sat_to_out = SAT_MAX[OUT_W_DEF-1:0];
      end else if (s < SAT_MIN) begin
         sat_to_out = SAT_MIN[OUT_W_DEF-1:0];
      end else begin
         sat_to_out = s[OUT_W_DEF-1:0];
      end
   endfunction

endpackage

// File: rtl/ulaw_to_fix14.sv
// Combinational u-law byte to 14-bit signed linear decoder (magnitude up to 8031).
module ulaw_to_fix14
   import nn_pkg::*;
(
   input  logic [7:0]                ulaw_i,
   output logic signed [FIX14_W-1:0] fix_o
);

   logic [7:0]         inv;
   logic [2:0]         seg;
   logic [3:0]         mant;
   logic [FIX14_W-1:0] mag;

   always_comb begin
      inv  = ~ulaw_i;
      seg  = inv[6:4];
      mant = inv[3:0];
      // Biased mantissa shifted by segment, then the bias of 33 removed.
      mag  = (({9'd0, mant, 1'b0} + 14'd33) << seg) - 14'd33;
      fix_o = inv[7] ? -$signed(mag) : $signed(mag);
   end

endmodule

// File: rtl/ulaw_neuron_mac.sv
// Streaming neuron MAC: u-law weights times unsigned activations, accumulated,
// then bias, arithmetic shift, optional ReLU and saturation to OUT_W bits.
module ulaw_neuron_mac
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 784,
   parameter int ACT_W    = 8,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter int SHIFT    = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [ACC_W-1:0] bias,
   input  logic                    relu_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              w_ulaw,
   input  logic [ACT_W-1:0]        act,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    busy,
   output logic                    err_len
);

   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int PROD_W = FIX14_W + ACT_W + 1;

   state_e state_q, state_d;

   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   bias_q;
   logic                      relu_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      term_q;
   logic                      err_q;
   logic                      p1_vld_q;
   logic                      p1_last_q;
   logic signed [FIX14_W-1:0] p1_w_q;
   logic [ACT_W-1:0]          p1_act_q;
   logic                      p2_last_q;
   logic signed [OUT_W-1:0]   out_data_q;
   logic                      out_valid_q;

   logic signed [FIX14_W-1:0] w_dec;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W:0]     sum;
   logic signed [ACC_W:0]     shifted;
   logic signed [ACC_W:0]     clipped;
   logic                      beat;
   logic                      cnt_end;
   logic                      term;

   ulaw_to_fix14 u_dec (
      .ulaw_i (w_ulaw),
      .fix_o  (w_dec)
   );

   // Handshake: a beat transfers on a rising edge where in_valid & in_ready are
   // both high; the result transfers where out_valid & out_ready are both high.
   always_comb begin
      state_d  = state_q;
      in_ready = (state_q == ACC) && !term_q;
      busy     = (state_q != IDLE);
      unique case (state_q)
         IDLE:    if (start) state_d = ACC;
         ACC:     if (p2_last_q) state_d = FIN;
         FIN:     state_d = OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      beat    = in_valid && in_ready;
      cnt_end = (cnt_q == CNT_W'(N_INPUTS - 1));
      term    = in_last || cnt_end;
      prod    = p1_w_q * $signed({1'b0, p1_act_q});
      sum     = {acc_q[ACC_W-1], acc_q} + {bias_q[ACC_W-1], bias_q};
      shifted = sum >>> SHIFT;
      clipped = (relu_q && (shifted < 0)) ? '0 : shifted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         bias_q      <= '0;
         relu_q      <= 1'b0;
         cnt_q       <= '0;
         term_q      <= 1'b0;
         err_q       <= 1'b0;
         p1_vld_q    <= 1'b0;
         p1_last_q   <= 1'b0;
         p1_w_q      <= '0;
         p1_act_q    <= '0;
         p2_last_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               acc_q     <= '0;
               cnt_q     <= '0;
               term_q    <= 1'b0;
               err_q     <= 1'b0;
               bias_q    <= bias;
               relu_q    <= relu_en;
               p1_vld_q  <= 1'b0;
               p2_last_q <= 1'b0;
            end
            ACC: begin
               p1_vld_q <= beat;
               if (beat) begin
                  p1_w_q    <= w_dec;
                  p1_act_q  <= act;
                  p1_last_q <= term;
                  cnt_q     <= cnt_q + 1'b1;
                  if (term) term_q <= 1'b1;
                  // The beat ends the neuron, but the two end markers disagree.
                  if (in_last != cnt_end) err_q <= 1'b1;
               end
               if (p1_vld_q) begin
                  acc_q     <= acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                  p2_last_q <= p1_last_q;
               end
            end
            FIN: begin
               out_data_q  <= sat_to_out(clipped);
               out_valid_q <= 1'b1;
            end
            OUT: if (out_ready) out_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err_len   = err_q;

endmodule

// File: tb/tb_ulaw_neuron_mac.sv
// Bench for ulaw_neuron_mac: two instances (SHIFT 0 and 4) share one stream;
// a G.711-style reference model predicts each result, err_len and timing.
module tb_ulaw_neuron_mac;

   localparam int N   = 4;
   localparam int SH0 = 0;
   localparam int SH1 = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [31:0] bias;
   logic               relu_en;
   logic               in_valid;
   logic [7:0]         w_ulaw;
   logic [7:0]         act;
   logic               in_last;
   logic               out_ready;
   logic               in_ready0, in_ready1;
   logic               out_valid0, out_valid1;
   logic signed [15:0] out_data0, out_data1;
   logic               busy0, busy1;
   logic               err_len0, err_len1;

   int n_checks = 0;
   int n_fail   = 0;

   // {err, result at SH1, result at SH0}
   logic [32:0] exp_q[$];

   logic signed [15:0] last_out0, last_out1;
   logic               last_err;

   always #5 clk = ~clk;

   ulaw_neuron_mac #(.N_INPUTS(N), .SHIFT(SH0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready0), .w_ulaw(w_ulaw), .act(act),
      .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .busy(busy0), .err_len(err_len0)
   );

   ulaw_neuron_mac #(.N_INPUTS(N), .SHIFT(SH1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .relu_en(relu_en),
      .in_valid(in_valid), .in_ready(in_ready1), .w_ulaw(w_ulaw), .act(act),
      .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .busy(busy1), .err_len(err_len1)
   );

   task automatic check(input string name, input logic signed [63:0] actual,
                        input logic signed [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // u-law: complement the byte; sign, 3-bit segment, 4-bit mantissa.
   function automatic longint decode(input logic [7:0] b);
      logic [7:0] inv;
      longint mag;
      inv = ~b;
      mag = (2 * longint'(inv[3:0]) + 33) * (longint'(1) << inv[6:4]) - 33;
      return inv[7] ? -mag : mag;
   endfunction

   function automatic longint model_out(input longint total, input int sh, input bit relu);
      longint d, s;
      d = longint'(1) << sh;
      s = total / d;
      if (total < 0 && (total % d) != 0) s = s - 1;
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // Compare process: every cycle the result is presented.
   always @(negedge clk) begin
      if (rst_n && out_valid0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out actual=%0d expected=none", out_data0);
         end else begin
            check("out_data_sh0", out_data0, $signed(exp_q[0][15:0]));
            check("out_data_sh1", out_data1, $signed(exp_q[0][31:16]));
            check("out_valid_sh1", out_valid1, 1);
            check("err_len_sh0", err_len0, exp_q[0][32]);
            check("err_len_sh1", err_len1, exp_q[0][32]);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic run_neuron(input logic signed [31:0] b, input bit relu,
                             input logic [7:0] ws[4], input logic [7:0] as[4],
                             input int last_idx, input int bubble_max, input int hold);
      int     term;
      longint total;
      longint s0, s1;
      bit     err;
      bit     done;
      term  = (last_idx < N - 1) ? last_idx : N - 1;
      err   = (last_idx != N - 1);
      total = longint'(b);
      for (int i = 0; i <= term; i++) total += decode(ws[i]) * longint'(as[i]);
      s0 = model_out(total, SH0, relu);
      s1 = model_out(total, SH1, relu);
      exp_q.push_back({err, s1[15:0], s0[15:0]});

      start = 1'b1; bias = b; relu_en = relu;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_clears_err", err_len0, 0);
      check("busy_in_acc", busy0, 1);
      for (int i = 0; i <= term; i++) begin
         repeat ($urandom_range(0, bubble_max)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         check("in_ready_acc", in_ready0, 1);
         check("in_ready_acc_sh1", in_ready1, 1);
         in_valid = 1'b1; w_ulaw = ws[i]; act = as[i]; in_last = (i == last_idx);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("in_ready_after_term", in_ready0, 0);
      @(posedge clk); #1;
      check("out_valid_t1", out_valid0, 0);
      @(posedge clk); #1;
      check("out_valid_t2", out_valid0, 0);
      @(posedge clk); #1;
      check("out_valid_t3", out_valid0, 1);
      last_out0 = out_data0;
      last_out1 = out_data1;
      last_err  = err_len0;

      start = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         check("hold_valid", out_valid0, 1);
         check("hold_data", out_data0, last_out0);
         check("hold_in_ready", in_ready0, 0);
         check("hold_busy", busy0, 1);
      end
      start = 1'b0;
      out_ready = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         @(posedge clk); #1;
         if (!out_valid0) done = 1'b1;
      end
      check("handshake_done", done, 1);
      check("idle_after_out", busy0, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] ws[4];
      logic [7:0] as[4];
      logic signed [31:0] b;

      rst_n = 1'b0; start = 1'b0; bias = '0; relu_en = 1'b0;
      in_valid = 1'b0; w_ulaw = '0; act = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready0, 0);
      check("rst_out_valid", out_valid0, 0);
      check("rst_busy", busy0, 0);
      check("rst_err_len", err_len0, 0);
      check("rst_out_data", out_data0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      ws = '{8'h80, 8'hFF, 8'hFF, 8'hFF}; as = '{8'd1, 8'd9, 8'd9, 8'd9};
      run_neuron(0, 1'b0, ws, as, 3, 0, 0);
      check("lit_basic", last_out0, 8031);
      check("lit_basic_sh4", last_out1, 501);
      check("lit_basic_err", last_err, 0);

      ws[0] = 8'h00;
      run_neuron(0, 1'b0, ws, as, 3, 1, 0);
      check("lit_neg", last_out0, -8031);
      check("lit_neg_sh4", last_out1, -502);
      run_neuron(0, 1'b1, ws, as, 3, 0, 0);
      check("lit_relu", last_out0, 0);

      ws = '{8'h80, 8'h80, 8'h80, 8'h80}; as = '{8'd255, 8'd255, 8'd255, 8'd255};
      run_neuron(0, 1'b0, ws, as, 3, 0, 0);
      check("lit_sat", last_out0, 32767);

      ws = '{8'hFE, 8'hEF, 8'hFF, 8'hFF}; as = '{8'd1, 8'd1, 8'd1, 8'd1};
      run_neuron(0, 1'b0, ws, as, 3, 0, 0);
      check("lit_decode", last_out0, 35);

      ws = '{8'h80, 8'hFF, 8'hFF, 8'hFF}; as = '{8'd1, 8'd9, 8'd9, 8'd9};
      run_neuron(0, 1'b0, ws, as, 3, 0, 5);
      check("lit_backpressure", last_out0, 8031);

      ws = '{8'h80, 8'h80, 8'h80, 8'h80}; as = '{8'd1, 8'd1, 8'd1, 8'd1};
      run_neuron(0, 1'b0, ws, as, 1, 0, 0);
      check("lit_len_err", last_out0, 16062);
      check("lit_len_err_flag", last_err, 1);

      // Reset in the middle of accumulation.
      start = 1'b1; bias = 32'sd1000; relu_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; w_ulaw = 8'h80; act = 8'd200;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready0, 0);
      check("mid_rst_out_valid", out_valid0, 0);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_err_len", err_len0, 0);
      check("mid_rst_out_data", out_data0, 0);
      check("mid_rst_out_data_sh1", out_data1, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      ws = '{8'hFE, 8'hEF, 8'hFF, 8'hFF}; as = '{8'd1, 8'd1, 8'd1, 8'd1};
      run_neuron(0, 1'b0, ws, as, 3, 0, 0);
      check("lit_after_rst", last_out0, 35);

      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 4; i++) begin
            ws[i] = 8'($urandom);
            as[i] = 8'($urandom);
         end
         if ($urandom_range(0, 3) == 0) b = $signed($urandom);
         else b = $signed(32'($urandom_range(0, 80000))) - 32'sd40000;
         run_neuron(b, 1'($urandom_range(0, 1)), ws, as, $urandom_range(0, 4),
                    2, $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      check("exp_queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ulaw_neuron_mac.md
Name: ulaw_neuron_mac

Overview:
- Streaming multiply-accumulate stage for one fully-connected neuron.
- Consumes u-law-compressed weight bytes paired with 8-bit unsigned activations (pixels or previous-layer outputs).
- Decodes each weight to 14-bit signed fixed point by instantiating ulaw_to_fix14, then accumulates the dot product.
- Finishes with bias add, scaling shift, optional ReLU and saturation; sits between the weight/activation fetch sequencer and the layer result buffer.

Parameters:
- N_INPUTS, 784, beats per neuron (dot-product length).
- ACT_W, 8, unsigned activation width.
- ACC_W, 32, signed accumulator and bias width.
- OUT_W, 16, signed result width.
- SHIFT, 13, arithmetic right shift applied to (acc + bias).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse in IDLE: begin a new neuron.
- bias  in  ACC_W  signed bias, sampled on accepted start.
- relu_en  in  1  sampled on accepted start; 1 clamps negative results to 0.
- in_valid  in  1  weight/activation beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- w_ulaw  in  8  u-law weight byte.
- act  in  ACT_W  unsigned activation.
- in_last  in  1  marks final beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  signed result.
- busy  out  1  high in any state except IDLE.
- err_len  out  1  sticky length mismatch; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; in_ready, out_valid, busy, err_len = 0; out_data = 0; accumulator, beat counter and pipeline valid bits cleared.
- A reset mid-operation discards the neuron in progress; no partial result is ever emitted.
- States: IDLE, ACC, FIN, OUT.
- IDLE: start=1 → clear acc and count, latch bias and relu_en, clear err_len, go to ACC. start is ignored in every other state.
- ACC: in_ready = 1 until the terminating beat is accepted, then 0.
  - P1 register: on each accepted beat, captures the decoded 14-bit signed weight, act, a last flag and a valid bit.
  - P2: acc <= acc + sext(wdec * {0,act}). The product is signed 14 × unsigned 8, 23 bits.
  - When P2 consumes the last-flagged beat, go to FIN.
- Terminating beat: the first of (in_last=1) or (count == N_INPUTS-1).
  - If these two conditions disagree on that beat, set err_len=1. The result is still produced from the beats actually accepted.
- FIN (one cycle):
  - s = (acc + bias) >>> SHIFT (arithmetic, truncation toward −inf).
  - If relu_en and s < 0, s = 0.
  - Saturate s to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and register it into out_data.
  - Set out_valid = 1 and go to OUT.
- Latency: terminating beat accepted at edge T → out_valid high after edge T+3.
- OUT: out_data and out_valid are held stable until out_valid & out_ready; at that edge out_valid drops and the state goes to IDLE. The next start is accepted one cycle later at the earliest.
- Bubbles: in_valid may drop at any point in ACC. P1/P2 advance only valid beats; the accumulator holds on bubbles.
- Width: ACC_W=32 covers 784 × 8159 × 255 without overflow; the sum acc + bias is computed at ACC_W+1 bits before the shift.

Decomposition:
- Shared package nn_pkg holds:
  - state enum (IDLE, ACC, FIN, OUT);
  - FIX14_W = 14;
  - the ACC_W/OUT_W defaults;
  - a saturation function sat_to_out.
- Natural sub-module: the existing ulaw_to_fix14, instantiated combinationally ahead of the P1 register.
- The MAC datapath stays inline.

Test Plan:
- N_INPUTS=4, SHIFT=0, bias 0, relu_en 0; w = 0x80,0xFF,0xFF,0xFF; act = 1,9,9,9; in_last on beat 4 → out_data = 8031, out_valid 3 edges after the last beat, err_len 0.
- Same setup with w[0] = 0x00 (−8031) → out_data = −8031; repeat with relu_en=1 → out_data = 0.
- Saturation: four beats of 0x80 with act 255, SHIFT=0 → sum 8,191,620 → out_data = 32767. Also check decodes 0xFE→2, 0xEF→33 with act 1 → 35.
- Backpressure: out_ready low for 5 cycles → out_data and out_valid stable, in_ready 0, start ignored; out_ready high → IDLE next cycle.
- Length error: in_last on beat 2 of N_INPUTS=4, w=0x80, act=1 → err_len=1, out_data = 16062. The next start clears err_len.
- Reset mid-ACC after 2 beats → all outputs 0 immediately; a fresh start with 4 beats gives the correct result with no residue from before the reset.
